// File: rtl/tdd_frame_sched.sv
// tdd_frame_sched: frame timing controller counting sample strobes into frames with
// one-shot length adjustment and TDD TX/RX gating windows.
module tdd_frame_sched #(
  parameter int CW = 24,
  parameter int FW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          tddmode_i,
  input  logic          sample_stb_i,
  input  logic [CW-1:0] frame_len_i,
  input  logic [CW-1:0] frame_adj_i,
  input  logic          adj_wr_i,
  input  logic [CW-1:0] tstart_i,
  input  logic [CW-1:0] tend_i,
  input  logic [CW-1:0] rstart_i,
  input  logic [CW-1:0] rend_i,
  output logic [CW-1:0] cnt_o,
  output logic [FW-1:0] frame_no_o,
  output logic          sof_o,
  output logic          tx_win_o,
  output logic          rx_win_o,
  output logic          adj_pending_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d, ts_q, ts_d, te_q, te_d, rs_q, rs_d, re_q, re_d;
  logic          tdd_q, tdd_d, adj_act_q, adj_act_d, adj_pend_q, adj_pend_d;
  logic [CW-1:0] adj_sh_q, adj_sh_d, adj_val_q, adj_val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frame_no_q, frame_no_d;
  logic          sof_q, sof_d, tx_q, tx_d, rx_q, rx_d;
  logic [CW-1:0] len_nom, eff_len;
  logic [CW+1:0] sum;
  logic          enter, wrap, load;

  function automatic logic in_win(input logic [CW-1:0] c, s, e);
    return (s <= e) ? (c >= s && c <= e) : (c >= s || c <= e);
  endfunction

  // Two guard bits keep len + adj exact so both the <1 and >max clamps are clean.
  always_comb begin
    len_nom    = (len_q == '0) ? CW'(1) : len_q;
    sum        = {2'b00, len_nom} + (adj_act_q ? {{2{adj_sh_q[CW-1]}}, adj_sh_q} : '0);
    eff_len    = (sum[CW+1] || sum == '0) ? CW'(1) : (sum[CW] ? '1 : sum[CW-1:0]);
    enter      = (state_q == IDLE) && en_i;
    wrap       = (state_q == RUN) && en_i && sample_stb_i && (cnt_q == eff_len - CW'(1));
    load       = enter || wrap;
    state_d    = en_i ? RUN : IDLE;
    cnt_d      = (!en_i || load) ? '0 : (sample_stb_i ? cnt_q + CW'(1) : cnt_q);
    frame_no_d = wrap ? frame_no_q + FW'(1) : frame_no_q;
    sof_d      = load;
    len_d      = load ? frame_len_i : len_q;
    ts_d       = load ? tstart_i : ts_q;
    te_d       = load ? tend_i : te_q;
    rs_d       = load ? rstart_i : rs_q;
    re_d       = load ? rend_i : re_q;
    tdd_d      = load ? tddmode_i : tdd_q;
    adj_act_d  = load ? adj_pend_q : adj_act_q;
    adj_sh_d   = load ? adj_val_q : adj_sh_q;
    adj_val_d  = adj_wr_i ? frame_adj_i : adj_val_q;
    adj_pend_d = adj_wr_i || (adj_pend_q && !load);
    tx_d       = en_i && (!tdd_d || in_win(cnt_d, ts_d, te_d));
    rx_d       = en_i && (!tdd_d || in_win(cnt_d, rs_d, re_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      ts_q       <= '0;
      te_q       <= '0;
      rs_q       <= '0;
      re_q       <= '0;
      tdd_q      <= 1'b0;
      adj_act_q  <= 1'b0;
      adj_sh_q   <= '0;
      adj_val_q  <= '0;
      adj_pend_q <= 1'b0;
      cnt_q      <= '0;
      frame_no_q <= '0;
      sof_q      <= 1'b0;
      tx_q       <= 1'b0;
      rx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ts_q       <= ts_d;
      te_q       <= te_d;
      rs_q       <= rs_d;
      re_q       <= re_d;
      tdd_q      <= tdd_d;
      adj_act_q  <= adj_act_d;
      adj_sh_q   <= adj_sh_d;
      adj_val_q  <= adj_val_d;
      adj_pend_q <= adj_pend_d;
      cnt_q      <= cnt_d;
      frame_no_q <= frame_no_d;
      sof_q      <= sof_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign frame_no_o    = frame_no_q;
  assign sof_o         = sof_q;
  assign tx_win_o      = tx_q;
  assign rx_win_o      = rx_q;
  assign adj_pending_o = adj_pend_q;
endmodule
